// File: rtl/pio_out_shifter.sv
// Output shift register for the PIO machine: OUT shifting, autopull refill,
// explicit PULL and MOV-to-OSR, with the pull/stall decision made locally.
module pio_out_shifter #(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          en,
    input  logic          shift_dir,
    input  logic          autopull,
    input  logic [CW-1:0] pull_thresh,
    input  logic          out_req,
    input  logic [CW-1:0] out_count,
    input  logic          pull_req,
    input  logic          pull_block,
    input  logic          pull_ifempty,
    input  logic [W-1:0]  x_in,
    input  logic          mov_set,
    input  logic [W-1:0]  mov_data,
    input  logic          fifo_valid,
    input  logic [W-1:0]  fifo_data,
    output logic          fifo_ready,
    output logic [W-1:0]  out_data,
    output logic          out_done,
    output logic          stall,
    output logic [W-1:0]  osr,
    output logic [CW-1:0] shift_count,
    output logic          osr_empty
);

    localparam logic [CW-1:0] W_CNT = CW'(W);
    localparam logic [W-1:0]  ONES  = '1;

    logic [W-1:0]  osr_q, osr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] thr, n, left_amt;
    logic [CW:0]   cnt_sum;
    logic [CW-1:0] cnt_sat;
    logic [W-1:0]  out_mask;
    logic          active, do_mov, do_pull, do_out;
    logic          refill, pull_skip;

    // Requests are only honoured on an enabled tick outside reset/restart,
    // which also keeps fifo_ready low while the machine is being reset.
    assign active  = en && !reset && !restart;
    assign do_mov  = active && mov_set;
    assign do_pull = active && !mov_set && pull_req;
    assign do_out  = active && !mov_set && !pull_req && out_req;

    assign thr       = (pull_thresh == '0) ? W_CNT : pull_thresh;
    assign n         = (out_count == '0) ? W_CNT : out_count;
    assign left_amt  = W_CNT - n;
    assign out_mask  = ~(ONES << n);
    assign osr_empty = (cnt_q >= thr);
    assign refill    = autopull && osr_empty;
    assign pull_skip = pull_ifempty && !osr_empty;

    // Count saturates at W so repeated OUTs on an empty OSR stay "empty".
    assign cnt_sum = {1'b0, cnt_q} + {1'b0, n};
    assign cnt_sat = (cnt_sum > {1'b0, W_CNT}) ? W_CNT : cnt_sum[CW-1:0];

    always_comb begin
        fifo_ready = 1'b0;
        out_data   = '0;
        out_done   = 1'b0;
        stall      = 1'b0;
        osr_d      = osr_q;
        cnt_d      = cnt_q;
        if (do_mov) begin
            osr_d    = mov_data;
            cnt_d    = '0;
            out_done = 1'b1;
        end else if (do_pull) begin
            if (pull_skip) begin
                out_done = 1'b1;
            end else if (fifo_valid) begin
                fifo_ready = 1'b1;
                osr_d      = fifo_data;
                cnt_d      = '0;
                out_done   = 1'b1;
            end else if (pull_block) begin
                stall = 1'b1;
            end else begin
                osr_d    = x_in;
                cnt_d    = '0;
                out_done = 1'b1;
            end
        end else if (do_out) begin
            if (refill) begin
                // Refill costs one tick; the OUT itself is retried next tick.
                stall = 1'b1;
                if (fifo_valid) begin
                    fifo_ready = 1'b1;
                    osr_d      = fifo_data;
                    cnt_d      = '0;
                end
            end else begin
                if (shift_dir) begin
                    out_data = osr_q & out_mask;
                    osr_d    = osr_q >> n;
                end else begin
                    out_data = osr_q >> left_amt;
                    osr_d    = osr_q << n;
                end
                cnt_d    = cnt_sat;
                out_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            osr_q <= '0;
            cnt_q <= W_CNT;
        end else if (en) begin
            osr_q <= osr_d;
            cnt_q <= cnt_d;
        end
    end

    assign osr         = osr_q;
    assign shift_count = cnt_q;

endmodule

// File: tb/tb_pio_out_shifter.sv
// Scoreboard bench for pio_out_shifter: a W=32 instance and a W=8 instance.
module tb_pio_out_shifter;

    logic        clk = 1'b0;
    logic        reset, restart, en, shift_dir, autopull;
    logic        out_req, pull_req, pull_block, pull_ifempty, mov_set, fifo_valid;
    logic [5:0]  pull_thresh, out_count;
    logic [31:0] x_in, mov_data, fifo_data;
    logic        fifo_ready, out_done, stall, osr_empty;
    logic [31:0] out_data, osr;
    logic [5:0]  shift_count;

    logic [3:0]  pull_thresh8, out_count8;
    logic [7:0]  x_in8, mov_data8, fifo_data8;
    logic        fifo_ready8, out_done8, stall8, osr_empty8;
    logic [7:0]  out_data8, osr8;
    logic [3:0]  shift_count8;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic        rst, en, mov, pull, out, blk, ife, fv;
        logic [31:0] fd, md, x;
        logic [5:0]  cnt;
    } stim_t;

    typedef struct packed {
        logic        fr, done, st;
        logic [31:0] od, osr;
        logic [5:0]  cnt;
        logic        emp;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } step_t;

    step_t plan[$];
    exp_t  sb[$];

    always #5 clk = ~clk;

    pio_out_shifter #(.W(32)) u_dut32 (
        .clk(clk), .reset(reset), .restart(restart), .en(en),
        .shift_dir(shift_dir), .autopull(autopull), .pull_thresh(pull_thresh),
        .out_req(out_req), .out_count(out_count), .pull_req(pull_req),
        .pull_block(pull_block), .pull_ifempty(pull_ifempty), .x_in(x_in),
        .mov_set(mov_set), .mov_data(mov_data), .fifo_valid(fifo_valid),
        .fifo_data(fifo_data), .fifo_ready(fifo_ready), .out_data(out_data),
        .out_done(out_done), .stall(stall), .osr(osr),
        .shift_count(shift_count), .osr_empty(osr_empty)
    );

    pio_out_shifter #(.W(8)) u_dut8 (
        .clk(clk), .reset(reset), .restart(restart), .en(en),
        .shift_dir(shift_dir), .autopull(autopull), .pull_thresh(pull_thresh8),
        .out_req(out_req), .out_count(out_count8), .pull_req(pull_req),
        .pull_block(pull_block), .pull_ifempty(pull_ifempty), .x_in(x_in8),
        .mov_set(mov_set), .mov_data(mov_data8), .fifo_valid(fifo_valid),
        .fifo_data(fifo_data8), .fifo_ready(fifo_ready8), .out_data(out_data8),
        .out_done(out_done8), .stall(stall8), .osr(osr8),
        .shift_count(shift_count8), .osr_empty(osr_empty8)
    );

    function automatic stim_t s_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t s_out(logic [5:0] c, logic fv, logic [31:0] fd);
        stim_t s;
        s = '0;
        s.en = 1'b1; s.out = 1'b1; s.cnt = c; s.fv = fv; s.fd = fd;
        return s;
    endfunction

    function automatic stim_t s_mov(logic [31:0] md);
        stim_t s;
        s = '0;
        s.en = 1'b1; s.mov = 1'b1; s.md = md;
        return s;
    endfunction

    function automatic stim_t s_pull(logic ife, logic blk, logic fv, logic [31:0] fd, logic [31:0] x);
        stim_t s;
        s = '0;
        s.en = 1'b1; s.pull = 1'b1; s.ife = ife; s.blk = blk; s.fv = fv; s.fd = fd; s.x = x;
        return s;
    endfunction

    function automatic exp_t ex(logic fr, logic done, logic st, logic [31:0] od,
                                logic [31:0] o, logic [5:0] c, logic emp);
        exp_t e;
        e.fr = fr; e.done = done; e.st = st; e.od = od; e.osr = o; e.cnt = c; e.emp = emp;
        return e;
    endfunction

    function automatic step_t mk(stim_t s, exp_t e);
        step_t p;
        p.s = s; p.e = e;
        return p;
    endfunction

    task automatic drive(stim_t s);
        restart = s.rst; en = s.en; mov_set = s.mov; pull_req = s.pull; out_req = s.out;
        pull_block = s.blk; pull_ifempty = s.ife; fifo_valid = s.fv;
        fifo_data = s.fd; mov_data = s.md; x_in = s.x; out_count = s.cnt;
        fifo_data8 = s.fd[7:0]; mov_data8 = s.md[7:0]; x_in8 = s.x[7:0]; out_count8 = s.cnt[3:0];
    endtask

    task automatic test_reset();
        reset = 1'b1; shift_dir = 1'b1; autopull = 1'b1; pull_thresh = 6'd32; pull_thresh8 = 4'd8;
        drive(s_out(6'd8, 1'b1, 32'h1111_1111));
        @(negedge clk);
        n_checks++;
        if ({fifo_ready, out_done, stall} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs ready/done/stall got %b%b%b want 000", fifo_ready, out_done, stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(s_idle());
        @(negedge clk);
        n_checks++;
        if (osr !== 32'h0 || shift_count !== 6'd32 || osr_empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state osr=%h cnt=%0d empty=%b want 0/32/1", osr, shift_count, osr_empty);
        end
        n_checks++;
        if ({fifo_ready, out_done, stall} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_outputs ready/done/stall got %b%b%b want 000", fifo_ready, out_done, stall);
        end
        n_checks++;
        if (osr8 !== 8'h0 || shift_count8 !== 4'd8) begin
            n_err++;
            $display("FAIL reset_state_w8 osr=%h cnt=%0d want 0/8", osr8, shift_count8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_autopull_right();
        step_t p;
        exp_t  e;
        int    i = 0;
        shift_dir = 1'b1; autopull = 1'b1; pull_thresh = 6'd32;
        plan.push_back(mk(s_out(6'd8, 1'b1, 32'hA5C3_0F12), ex(1, 0, 1, 32'h0,  32'hA5C3_0F12, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd8, 1'b0, 32'h0), ex(0, 1, 0, 32'h12, 32'h00A5_C30F, 6'd8,  0)));
        plan.push_back(mk(s_out(6'd8, 1'b0, 32'h0), ex(0, 1, 0, 32'h0F, 32'h0000_A5C3, 6'd16, 0)));
        plan.push_back(mk(s_out(6'd8, 1'b0, 32'h0), ex(0, 1, 0, 32'hC3, 32'h0000_00A5, 6'd24, 0)));
        plan.push_back(mk(s_out(6'd8, 1'b0, 32'h0), ex(0, 1, 0, 32'hA5, 32'h0,         6'd32, 1)));
        for (int k = 0; k < 3; k++)
            plan.push_back(mk(s_out(6'd8, 1'b0, 32'h0), ex(0, 0, 1, 32'h0, 32'h0, 6'd32, 1)));
        plan.push_back(mk(s_out(6'd8, 1'b1, 32'hDEAD_BEEF), ex(1, 0, 1, 32'h0, 32'hDEAD_BEEF, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd0, 1'b0, 32'h0), ex(0, 1, 0, 32'hDEAD_BEEF, 32'h0, 6'd32, 1)));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            drive(p.s);
            sb.push_back(p.e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({fifo_ready, out_done, stall} !== {e.fr, e.done, e.st} || out_data !== e.od) begin
                n_err++;
                $display("FAIL autopull[%0d] ready/done/stall/data got %b%b%b %h want %b%b%b %h",
                         i, fifo_ready, out_done, stall, out_data, e.fr, e.done, e.st, e.od);
            end
            @(posedge clk); #1;
            n_checks++;
            if (osr !== e.osr || shift_count !== e.cnt || osr_empty !== e.emp) begin
                n_err++;
                $display("FAIL autopull[%0d] osr/cnt/empty got %h %0d %b want %h %0d %b",
                         i, osr, shift_count, osr_empty, e.osr, e.cnt, e.emp);
            end
            i++;
        end
        drive(s_idle());
    endtask

    task automatic test_left_mov();
        step_t p;
        exp_t  e;
        int    i = 0;
        shift_dir = 1'b0; autopull = 1'b0; pull_thresh = 6'd32;
        plan.push_back(mk(s_mov(32'hF000_0001), ex(0, 1, 0, 32'h0, 32'hF000_0001, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd4, 1'b0, 32'h0), ex(0, 1, 0, 32'hF, 32'h0000_0010, 6'd4, 0)));
        plan.push_back(mk(s_out(6'd0, 1'b0, 32'h0), ex(0, 1, 0, 32'h0000_0010, 32'h0, 6'd32, 1)));
        plan.push_back(mk(s_out(6'd4, 1'b1, 32'h9), ex(0, 1, 0, 32'h0, 32'h0, 6'd32, 1)));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            drive(p.s);
            sb.push_back(p.e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({fifo_ready, out_done, stall} !== {e.fr, e.done, e.st} || out_data !== e.od) begin
                n_err++;
                $display("FAIL left_mov[%0d] ready/done/stall/data got %b%b%b %h want %b%b%b %h",
                         i, fifo_ready, out_done, stall, out_data, e.fr, e.done, e.st, e.od);
            end
            @(posedge clk); #1;
            n_checks++;
            if (osr !== e.osr || shift_count !== e.cnt || osr_empty !== e.emp) begin
                n_err++;
                $display("FAIL left_mov[%0d] osr/cnt/empty got %h %0d %b want %h %0d %b",
                         i, osr, shift_count, osr_empty, e.osr, e.cnt, e.emp);
            end
            i++;
        end
        drive(s_idle());
    endtask

    task automatic test_pull();
        step_t p;
        exp_t  e;
        int    i = 0;
        shift_dir = 1'b1; autopull = 1'b0; pull_thresh = 6'd16;
        plan.push_back(mk(s_mov(32'h0000_FF00), ex(0, 1, 0, 32'h0, 32'h0000_FF00, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd8, 1'b0, 32'h0), ex(0, 1, 0, 32'h0, 32'h0000_00FF, 6'd8, 0)));
        plan.push_back(mk(s_pull(1, 0, 1, 32'h9999, 32'h0), ex(0, 1, 0, 32'h0, 32'h0000_00FF, 6'd8, 0)));
        for (int k = 0; k < 3; k++)
            plan.push_back(mk(s_pull(0, 1, 0, 32'h0, 32'h0), ex(0, 0, 1, 32'h0, 32'h0000_00FF, 6'd8, 0)));
        plan.push_back(mk(s_pull(0, 1, 1, 32'h1234, 32'h0), ex(1, 1, 0, 32'h0, 32'h0000_1234, 6'd0, 0)));
        plan.push_back(mk(s_pull(0, 0, 0, 32'h0, 32'h55), ex(0, 1, 0, 32'h0, 32'h0000_0055, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd0, 1'b0, 32'h0), ex(0, 1, 0, 32'h55, 32'h0, 6'd32, 1)));
        plan.push_back(mk(s_pull(1, 0, 1, 32'hCAFE, 32'h0), ex(1, 1, 0, 32'h0, 32'h0000_CAFE, 6'd0, 0)));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            drive(p.s);
            sb.push_back(p.e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({fifo_ready, out_done, stall} !== {e.fr, e.done, e.st} || out_data !== e.od) begin
                n_err++;
                $display("FAIL pull[%0d] ready/done/stall/data got %b%b%b %h want %b%b%b %h",
                         i, fifo_ready, out_done, stall, out_data, e.fr, e.done, e.st, e.od);
            end
            @(posedge clk); #1;
            n_checks++;
            if (osr !== e.osr || shift_count !== e.cnt || osr_empty !== e.emp) begin
                n_err++;
                $display("FAIL pull[%0d] osr/cnt/empty got %h %0d %b want %h %0d %b",
                         i, osr, shift_count, osr_empty, e.osr, e.cnt, e.emp);
            end
            i++;
        end
        drive(s_idle());
    endtask

    task automatic test_priority_en();
        step_t p;
        exp_t  e;
        stim_t s;
        int    i = 0;
        shift_dir = 1'b1; autopull = 1'b1; pull_thresh = 6'd32;
        s = s_mov(32'h1111_2222); s.out = 1'b1; s.pull = 1'b1; s.fv = 1'b1; s.cnt = 6'd8;
        plan.push_back(mk(s, ex(0, 1, 0, 32'h0, 32'h1111_2222, 6'd0, 0)));
        s = s_mov(32'h3333_3333); s.out = 1'b1; s.fv = 1'b1; s.cnt = 6'd8; s.en = 1'b0;
        plan.push_back(mk(s, ex(0, 0, 0, 32'h0, 32'h1111_2222, 6'd0, 0)));
        s = s_out(6'd8, 1'b1, 32'h4444_4444); s.en = 1'b0;
        plan.push_back(mk(s, ex(0, 0, 0, 32'h0, 32'h1111_2222, 6'd0, 0)));
        s = s_pull(0, 0, 1, 32'h77, 32'h0); s.out = 1'b1; s.cnt = 6'd8;
        plan.push_back(mk(s, ex(1, 1, 0, 32'h0, 32'h0000_0077, 6'd0, 0)));
        s = s_out(6'd8, 1'b1, 32'h5555_5555); s.rst = 1'b1;
        plan.push_back(mk(s, ex(0, 0, 0, 32'h0, 32'h0, 6'd32, 1)));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            drive(p.s);
            sb.push_back(p.e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({fifo_ready, out_done, stall} !== {e.fr, e.done, e.st} || out_data !== e.od) begin
                n_err++;
                $display("FAIL priority[%0d] ready/done/stall/data got %b%b%b %h want %b%b%b %h",
                         i, fifo_ready, out_done, stall, out_data, e.fr, e.done, e.st, e.od);
            end
            @(posedge clk); #1;
            n_checks++;
            if (osr !== e.osr || shift_count !== e.cnt || osr_empty !== e.emp) begin
                n_err++;
                $display("FAIL priority[%0d] osr/cnt/empty got %h %0d %b want %h %0d %b",
                         i, osr, shift_count, osr_empty, e.osr, e.cnt, e.emp);
            end
            i++;
        end
        drive(s_idle());
    endtask

    task automatic test_w8_thresh();
        step_t p;
        exp_t  e;
        int    i = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        shift_dir = 1'b1; autopull = 1'b1; pull_thresh8 = 4'd6;
        plan.push_back(mk(s_out(6'd3, 1'b0, 32'h0),  ex(0, 0, 1, 32'h0, 32'h00, 6'd8, 1)));
        plan.push_back(mk(s_mov(32'hC5),             ex(0, 1, 0, 32'h0, 32'hC5, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd3, 1'b0, 32'h0),  ex(0, 1, 0, 32'h5, 32'h18, 6'd3, 0)));
        plan.push_back(mk(s_out(6'd3, 1'b0, 32'h0),  ex(0, 1, 0, 32'h0, 32'h03, 6'd6, 1)));
        plan.push_back(mk(s_out(6'd3, 1'b1, 32'h3C), ex(1, 0, 1, 32'h0, 32'h3C, 6'd0, 0)));
        plan.push_back(mk(s_out(6'd3, 1'b0, 32'h0),  ex(0, 1, 0, 32'h4, 32'h07, 6'd3, 0)));
        plan.push_back(mk(s_out(6'd0, 1'b0, 32'h0),  ex(0, 1, 0, 32'h7, 32'h00, 6'd8, 1)));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            drive(p.s);
            sb.push_back(p.e);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({fifo_ready8, out_done8, stall8} !== {e.fr, e.done, e.st} || out_data8 !== e.od[7:0]) begin
                n_err++;
                $display("FAIL w8[%0d] ready/done/stall/data got %b%b%b %h want %b%b%b %h",
                         i, fifo_ready8, out_done8, stall8, out_data8, e.fr, e.done, e.st, e.od[7:0]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (osr8 !== e.osr[7:0] || shift_count8 !== e.cnt[3:0] || osr_empty8 !== e.emp) begin
                n_err++;
                $display("FAIL w8[%0d] osr/cnt/empty got %h %0d %b want %h %0d %b",
                         i, osr8, shift_count8, osr_empty8, e.osr[7:0], e.cnt[3:0], e.emp);
            end
            i++;
        end
        drive(s_idle());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_autopull_right();
        test_left_mov();
        test_pull();
        test_priority_en();
        test_w8_thresh();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
